// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 master, MSB first. It sends one DATA_W-bit word per
// frame on spi_sclk/spi_mosi/spi_cs_n and uses a start/busy/done handshake.
// Optional build macro SPI_MASTER_QUEUE_EN adds a one-entry pending word.
// When that word is present, the next frame starts straight after the gap.
// Every output is a register. Its next value is decoded from the next state.
module spi_master_tx #(
    parameter int DATA_W  = 3,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     ph, ph_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic [DATA_W-1:0] sreg, sreg_nx;
    logic              phase_end;
    logic              sclk_nx, mosi_nx, cs_n_nx, busy_nx, done_nx;
    logic              pend_vld;
    logic [DATA_W-1:0] pend;

    assign phase_end = (ph == PH_LAST);

`ifdef SPI_MASTER_QUEUE_EN
    logic              pend_vld_nx;
    logic [DATA_W-1:0] pend_nx;

    // Pending slot: take a word offered while busy; free the slot at the end of the gap
    always_comb begin
        pend_vld_nx = pend_vld;
        pend_nx     = pend;
        if (state == GAP && phase_end) begin
            pend_vld_nx = 1'b0;
        end else if (state != IDLE && start && !pend_vld) begin
            pend_vld_nx = 1'b1;
            pend_nx     = data_in;
        end
    end

    // Pending slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend     <= '0;
        end else begin
            pend_vld <= pend_vld_nx;
            pend     <= pend_nx;
        end
    end
`else
    assign pend_vld = 1'b0;
    assign pend     = '0;
`endif

    // Next state, counters and shift register, then decode the next outputs
    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        bit_nx   = bit_cnt;
        sreg_nx  = sreg;
        case (state)
            IDLE: begin
                if (start) begin
                    sreg_nx  = data_in;
                    state_nx = SETUP;
                    ph_nx    = '0;
                    bit_nx   = '0;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    ph_nx    = '0;
                    state_nx = SCLK_HI;
                end else begin
                    ph_nx = ph + PW'(1);
                end
            end
            SCLK_HI: begin
                if (phase_end) begin
                    ph_nx    = '0;
                    state_nx = SCLK_LO;
                    // the next bit appears on mosi in the same cycle that sclk falls
                    sreg_nx  = sreg << 1;
                end else begin
                    ph_nx = ph + PW'(1);
                end
            end
            SCLK_LO: begin
                if (phase_end) begin
                    ph_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nx   = '0;
                        state_nx = GAP;
                    end else begin
                        bit_nx   = bit_cnt + BW'(1);
                        state_nx = SCLK_HI;
                    end
                end else begin
                    ph_nx = ph + PW'(1);
                end
            end
            GAP: begin
                if (phase_end) begin
                    ph_nx    = '0;
                    state_nx = IDLE;
`ifdef SPI_MASTER_QUEUE_EN
                    if (pend_vld) begin
                        sreg_nx  = pend;
                        state_nx = SETUP;
                    end else if (start) begin
                        sreg_nx  = data_in;
                        state_nx = SETUP;
                    end
`endif
                end else begin
                    ph_nx = ph + PW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        sclk_nx = (state_nx == SCLK_HI);
        cs_n_nx = !(state_nx == SETUP || state_nx == SCLK_HI || state_nx == SCLK_LO);
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == GAP) && (ph_nx == PH_LAST);
        mosi_nx = cs_n_nx ? 1'b0 : sreg_nx[DATA_W-1];
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            ph       <= ph_nx;
            bit_cnt  <= bit_nx;
            sreg     <= sreg_nx;
            spi_sclk <= sclk_nx;
            spi_mosi <= mosi_nx;
            spi_cs_n <= cs_n_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bench for spi_master_tx.
// Instance dut uses DATA_W=3, CLK_DIV=2 and instance dut8 uses DATA_W=8, CLK_DIV=1.
// Expected waveforms come from the frame timing:
// cs_n is low for L + 2*L*N cycles, the sclk rising edges start L cycles after cs_n falls,
// and a gap of L cycles ends with done.
module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start8;
    logic [2:0] data_in;
    logic [7:0] data8;
    logic       busy, done, sclk, mosi, cs_n;
    logic       busy8, done8, sclk8, mosi8, cs_n8;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    spi_master_tx #(.DATA_W(3), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n)
    );

    spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(data8),
        .busy(busy8), .done(done8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_cs_n(cs_n8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one frame cycle by cycle, from T1 to the done cycle, and stops on the done cycle.
    // issue: drive start at T0. hold: keep start high.
    // inject: offer a second word at T5 while the frame is busy.
    task automatic frame(input bit w8, input logic [7:0] d, input bit issue,
                         input bit hold, input bit inject, input logic [2:0] inj_d);
        int L, N, last_t, p;
        bit in_sh, e_sclk, e_csn;
        logic [3:0] ctl;
        logic       mo;
        L = w8 ? 1 : 2;
        N = w8 ? 8 : 3;
        last_t = 2 * L + 2 * L * N;
        if (issue) begin
            if (w8) begin start8 = 1'b1; data8 = d; end
            else    begin start  = 1'b1; data_in = d[2:0]; end
        end
        tick();
        if (!hold) begin
            start   = 1'b0;
            start8  = 1'b0;
            data_in = ~d[2:0];
            data8   = ~d;
        end
        for (int t = 1; t <= last_t; t++) begin
            p      = t - L - 1;
            in_sh  = (t >= L + 1) && (t <= L + 2 * L * N);
            e_sclk = in_sh && ((p % (2 * L)) < L);
            e_csn  = !((t >= 1) && (t <= L + 2 * L * N));
            ctl    = w8 ? {cs_n8, sclk8, busy8, done8} : {cs_n, sclk, busy, done};
            mo     = w8 ? mosi8 : mosi;
            chk($sformatf("ctl_w%0d_T%0d", N, t), 32'(ctl),
                32'({e_csn, e_sclk, 1'b1, (t == last_t)}));
            if (in_sh && (p % (2 * L)) == 0)
                chk($sformatf("mosi_rise_w%0d_T%0d", N, t), 32'(mo),
                    32'(d[N - 1 - p / (2 * L)]));
            if (e_csn)
                chk($sformatf("mosi_gap_w%0d_T%0d", N, t), 32'(mo), 32'(1'b0));
            if (inject && t == 5) begin start = 1'b1; data_in = inj_d; end
            if (inject && t == 6) start = 1'b0;
            if (t < last_t) tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0; data_in = '0; data8 = '0;
        #2;
        chk("reset_state", 32'({cs_n, sclk, mosi, busy, done}), 32'(5'b10000));
        repeat (3) tick();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle3", 32'({cs_n, sclk, mosi, busy, done}), 32'(5'b10000));
            chk("idle8", 32'({cs_n8, sclk8, mosi8, busy8, done8}), 32'(5'b10000));
        end

        // basic frame 3'b101
        frame(1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("after_101", 32'({busy, cs_n}), 32'(2'b01));

        // asynchronous reset mid-frame, then a clean frame
        start = 1'b1; data_in = 3'b111;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_frame_cs", 32'(cs_n), 32'(1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'({cs_n, sclk, busy, mosi, done}), 32'(5'b10000));
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'({cs_n, busy}), 32'(2'b10));
        frame(1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("after_010", 32'({busy, cs_n}), 32'(2'b01));

        // a second start while busy
        frame(1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 3'b100);
`ifdef SPI_MASTER_QUEUE_EN
        frame(1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("after_queue", 32'({busy, cs_n}), 32'(2'b01));
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ignored_start", 32'({busy, cs_n, sclk}), 32'(3'b010));
        end
`endif

        // start held high: back-to-back frames
        start = 1'b1; data_in = 3'b110;
        frame(1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 3'b000);
`ifndef SPI_MASTER_QUEUE_EN
        tick();
        chk("held_idle_cycle", 32'({busy, cs_n, done}), 32'(3'b010));
`endif
        frame(1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        chk("after_held", 32'({busy, cs_n}), 32'(2'b01));

        // wide word with CLK_DIV=1
        frame(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        chk("after_a5", 32'({busy8, cs_n8}), 32'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
